fire_conv_sequencer: RTL and testbench

- Controller for one fire-module expand convolution layer: a broadcast-pixel MAC array with one kernel ROM per DSP and per-output-pixel clear.
- Walks output pixels in raster order and, per pixel, every (channel, ky, kx) tap; generates ifm read address, weight ROM address, MAC enable, clear and sample strobes.
- Applies zero-padding for the 3x3 "same" window and stalls at pixel boundaries when the output RAM is not ready.
- Sits between the layer-chain start logic, the ifm RAM, the weight ROMs/MAC array and the ofm RAM.

---
 rtl/fire_conv_sequencer.sv | 166 ++++++++++++++++
 tb/tb_fire_conv_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fire_conv_sequencer.sv
`default_nettype none
// fire_conv_sequencer: raster pixel / (channel, ky, kx) tap sequencer for a fire-module expand conv layer.
// Define FIRE_SEQ_PERF_EN to add the saturating stall_cycles counter output.
module fire_conv_sequencer #(
  parameter int W_IN       = 32,
  parameter int CHIN       = 32,
  parameter int KERNEL_DIM = 3,
  parameter int IFM_AW     = $clog2(CHIN*W_IN*W_IN),
  parameter int WGT_AW     = $clog2(KERNEL_DIM*KERNEL_DIM*CHIN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    ofm_ready,
  input  logic                    ram_feedback,
  output logic                    layer_en,
  output logic [IFM_AW-1:0]       ifm_addr,
  output logic                    ifm_pad,
  output logic [WGT_AW-1:0]       weight_addr,
  output logic                    clr_pulse,
  output logic                    sample,
  output logic [$clog2(W_IN)-1:0] out_row,
  output logic [$clog2(W_IN)-1:0] out_col,
  output logic                    busy,
`ifdef FIRE_SEQ_PERF_EN
  output logic [31:0]             stall_cycles,
`endif
  output logic                    finish
);
  localparam int P    = (KERNEL_DIM - 1) / 2;
  localparam int NTAP = KERNEL_DIM * KERNEL_DIM * CHIN;
  localparam int RCW  = $clog2(W_IN);
  localparam int CW   = (CHIN > 1) ? $clog2(CHIN) : 1;
  localparam int KW   = (KERNEL_DIM > 1) ? $clog2(KERNEL_DIM) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_DRAIN0 = 3'd2,
    S_DRAIN1 = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [RCW-1:0]    row, col, tap_row, tap_col;
  logic [CW-1:0]     ch;
  logic [KW-1:0]     ky, kx;
  logic [WGT_AW-1:0] k;
  logic              fb_latched;
  logic              first_pix, last_tap, last_pix, stall, issue;
  logic [IFM_AW-1:0] addr_nxt;
  logic              pad_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    first_pix = (row == '0) && (col == '0);
    last_tap  = (k == WGT_AW'(NTAP - 1));
    last_pix  = (row == RCW'(W_IN - 1)) && (col == RCW'(W_IN - 1));
    // The pixel boundary is the only point where the ofm RAM can hold us off.
    stall     = (state == S_RUN) && (k == '0) && !ofm_ready && !first_pix;
    issue     = (state == S_RUN) && !stall;
    case (state)
      S_IDLE:   if (start) state_nxt = S_RUN;
      S_RUN:    if (issue && last_tap && last_pix) state_nxt = S_DRAIN0;
      S_DRAIN0: state_nxt = S_DRAIN1;
      S_DRAIN1: state_nxt = S_DONE;
      S_DONE:   if (ram_feedback || fb_latched) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    int iy, ix;
    iy       = int'(row) + int'(ky) - P;
    ix       = int'(col) + int'(kx) - P;
    pad_nxt  = (iy < 0) || (iy >= W_IN) || (ix < 0) || (ix >= W_IN);
    addr_nxt = pad_nxt ? '0 : IFM_AW'(int'(ch) * W_IN * W_IN + iy * W_IN + ix);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer_en    <= 1'b0;
      ifm_addr    <= '0;
      ifm_pad     <= 1'b0;
      weight_addr <= '0;
      clr_pulse   <= 1'b0;
      sample      <= 1'b0;
      out_row     <= '0;
      out_col     <= '0;
      tap_row     <= '0;
      tap_col     <= '0;
      row         <= '0;
      col         <= '0;
      ch          <= '0;
      ky          <= '0;
      kx          <= '0;
      k           <= '0;
      fb_latched  <= 1'b0;
    end else begin
      clr_pulse <= layer_en && (weight_addr == WGT_AW'(NTAP - 1));
      sample    <= clr_pulse;
      // Capture the completed pixel now; the tap registers move on to the next pixel this edge.
      if (layer_en && (weight_addr == WGT_AW'(NTAP - 1))) begin
        out_row <= tap_row;
        out_col <= tap_col;
      end
      layer_en <= issue;
      if ((state == S_IDLE) && start) begin
        row <= '0;
        col <= '0;
        ch  <= '0;
        ky  <= '0;
        kx  <= '0;
        k   <= '0;
      end else if (issue) begin
        ifm_addr    <= addr_nxt;
        ifm_pad     <= pad_nxt;
        weight_addr <= k;
        tap_row     <= row;
        tap_col     <= col;
        k           <= last_tap ? '0 : k + WGT_AW'(1);
        if (kx == KW'(KERNEL_DIM - 1)) begin
          kx <= '0;
          if (ky == KW'(KERNEL_DIM - 1)) begin
            ky <= '0;
            if (ch == CW'(CHIN - 1)) begin
              ch <= '0;
              if (col == RCW'(W_IN - 1)) begin
                col <= '0;
                row <= (row == RCW'(W_IN - 1)) ? '0 : row + RCW'(1);
              end else begin
                col <= col + RCW'(1);
              end
            end else begin
              ch <= ch + CW'(1);
            end
          end else begin
            ky <= ky + KW'(1);
          end
        end else begin
          kx <= kx + KW'(1);
        end
      end
      if (state == S_DONE)          fb_latched <= 1'b0;
      else if (busy && ram_feedback) fb_latched <= 1'b1;
    end
  end

  assign busy   = (state == S_RUN) || (state == S_DRAIN0) || (state == S_DRAIN1);
  assign finish = (state == S_DONE);

`ifdef FIRE_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               stall_cycles <= '0;
    else if ((state == S_IDLE) && start)      stall_cycles <= '0;
    else if (stall && (stall_cycles != '1))   stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fire_conv_sequencer.sv
`default_nettype none
// tb_fire_conv_sequencer: randomized and directed layer runs checked every cycle against a tap-count reference model.
module tb_fire_conv_sequencer;
  localparam int W   = 4;
  localparam int CH  = 2;
  localparam int K   = 3;
  localparam int NT  = K * K * CH;
  localparam int NP  = W * W;
  localparam int IAW = 5;
  localparam int WAW = 5;

  logic           clk = 1'b0;
  logic           rst_n, start, ofm_ready, ram_feedback;
  logic           layer_en, ifm_pad, clr_pulse, sample, busy, finish;
  logic [IAW-1:0] ifm_addr;
  logic [WAW-1:0] weight_addr;
  logic [1:0]     out_row, out_col;
`ifdef FIRE_SEQ_PERF_EN
  logic [31:0]    stall_cycles;
`endif

  int checks = 0;
  int failures = 0;

  // reference model state
  int          m_phase;  // 0 idle, 1 run, 2 drain, 3 done
  int          m_tap, m_dcnt;
  bit          m_fb;
  logic        e_en, e_pad, e_clr, e_sample, e_busy, e_finish;
  logic [31:0] e_ifm, e_wgt, e_row, e_col, e_stalls;

  int pix0_addr [NT];
  bit pix0_pad  [NT];

  fire_conv_sequencer #(.W_IN(W), .CHIN(CH), .KERNEL_DIM(K)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ofm_ready(ofm_ready),
    .ram_feedback(ram_feedback), .layer_en(layer_en), .ifm_addr(ifm_addr),
    .ifm_pad(ifm_pad), .weight_addr(weight_addr), .clr_pulse(clr_pulse),
    .sample(sample), .out_row(out_row), .out_col(out_col), .busy(busy),
`ifdef FIRE_SEQ_PERF_EN
    .stall_cycles(stall_cycles),
`endif
    .finish(finish)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_tap = 0; m_dcnt = 0; m_fb = 0;
    e_en = 0; e_pad = 0; e_clr = 0; e_sample = 0; e_busy = 0; e_finish = 0;
    e_ifm = 0; e_wgt = 0; e_row = 0; e_col = 0; e_stalls = 0;
  endtask

  // Expected addresses of global tap n, straight from the tap/pixel definitions.
  task automatic tap_expect(input int n);
    int p, kk, r, c, chn, ky, kx, iy, ix;
    p = n / NT; kk = n % NT;
    r = p / W;  c = p % W;
    chn = kk / (K * K); ky = (kk / K) % K; kx = kk % K;
    iy = r + ky - (K - 1) / 2; ix = c + kx - (K - 1) / 2;
    e_wgt = kk;
    e_pad = (iy < 0 || iy >= W || ix < 0 || ix >= W);
    e_ifm = e_pad ? 0 : chn * W * W + iy * W + ix;
  endtask

  task automatic compare_outputs();
    check("layer_en", layer_en, e_en);
    check("ifm_addr", ifm_addr, e_ifm);
    check("ifm_pad", ifm_pad, e_pad);
    check("weight_addr", weight_addr, e_wgt);
    check("clr_pulse", clr_pulse, e_clr);
    check("sample", sample, e_sample);
    check("out_row", out_row, e_row);
    check("out_col", out_col, e_col);
    check("busy", busy, e_busy);
    check("finish", finish, e_finish);
`ifdef FIRE_SEQ_PERF_EN
    check("stall_cycles", stall_cycles, e_stalls);
`endif
  endtask

  // Advance model and DUT by one clock with the inputs currently driven, then compare.
  task automatic step();
    bit new_clr;
    int pp;
    new_clr = e_en && (m_tap % NT == 0) && (m_tap != 0);
    if (new_clr) begin
      pp = (m_tap - 1) / NT;
      e_row = pp / W;
      e_col = pp % W;
    end
    e_sample = e_clr;
    e_clr    = new_clr;
    case (m_phase)
      0: begin
        e_en = 0;
        if (start) begin m_phase = 1; m_tap = 0; m_fb = 0; e_stalls = 0; end
      end
      1: begin
        if (ram_feedback) m_fb = 1;
        if ((m_tap % NT == 0) && (m_tap != 0) && !ofm_ready) begin
          e_en = 0;
          if (e_stalls != 32'hFFFF_FFFF) e_stalls++;
        end else begin
          e_en = 1;
          tap_expect(m_tap);
          m_tap++;
          if (m_tap == NP * NT) begin m_phase = 2; m_dcnt = 2; end
        end
      end
      2: begin
        e_en = 0;
        if (ram_feedback) m_fb = 1;
        m_dcnt--;
        if (m_dcnt == 0) m_phase = 3;
      end
      default: begin
        e_en = 0;
        if (ram_feedback || m_fb) begin m_phase = 0; m_fb = 0; end
      end
    endcase
    e_busy   = (m_phase == 1) || (m_phase == 2);
    e_finish = (m_phase == 3);
    @(posedge clk); #1;
    compare_outputs();
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    check({tag, "_en"}, layer_en, 0);
    check({tag, "_ifm"}, ifm_addr, 0);
    check({tag, "_pad"}, ifm_pad, 0);
    check({tag, "_wgt"}, weight_addr, 0);
    check({tag, "_clr"}, clr_pulse, 0);
    check({tag, "_sample"}, sample, 0);
    check({tag, "_row"}, out_row, 0);
    check({tag, "_col"}, out_col, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_finish"}, finish, 0);
`ifdef FIRE_SEQ_PERF_EN
    check({tag, "_stalls"}, stall_cycles, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // mode 0: clean run + start while busy; 1: 5-cycle stall at pixel 1; 2: random; 3: abort at tap 100
  task automatic run_layer(input int mode);
    int  cyc, en_cnt, clr_cnt, smp_cnt, low_cnt, stall_left;
    bit  seen_last, aborted, first_seen;
    cyc = 0; en_cnt = 0; clr_cnt = 0; smp_cnt = 0; low_cnt = 0;
    stall_left = 0; seen_last = 0; aborted = 0; first_seen = 0;
    ofm_ready = 1; ram_feedback = 0;
    start = 1; step(); start = 0;
    while (m_phase != 3 && cyc < 5000) begin
      ofm_ready = 1; ram_feedback = 0; start = 0;
      if (mode == 3 && m_tap == 100) begin
        do_reset("abort");
        aborted = 1;
        break;
      end
      case (mode)
        0: start = (cyc == 50);
        1: if (stall_left > 0) begin ofm_ready = 0; stall_left--; end
        2: begin
          ofm_ready    = ($urandom_range(0, 3) != 0);
          ram_feedback = ($urandom_range(0, 40) == 0);
          start        = ($urandom_range(0, 20) == 0);
        end
        default: ;
      endcase
      step();
      if (layer_en) begin
        if (!first_seen) begin
          first_seen = 1;
          check("first_tap_wgt", weight_addr, 0);
        end
        if (mode == 0 && en_cnt < NT) begin
          pix0_addr[en_cnt] = int'(ifm_addr);
          pix0_pad[en_cnt]  = ifm_pad;
        end
        en_cnt++;
        if (mode == 1 && !seen_last && weight_addr == WAW'(NT - 1)) begin
          seen_last  = 1;
          stall_left = 5;
        end
      end else if (en_cnt > 0 && en_cnt < NP * NT) begin
        low_cnt++;
      end
      if (clr_pulse) clr_cnt++;
      if (sample) smp_cnt++;
      cyc++;
    end
    if (aborted) begin
      clr_cnt = 0; smp_cnt = 0;
      repeat (20) begin
        step();
        if (clr_pulse) clr_cnt++;
        if (sample) smp_cnt++;
      end
      check("post_abort_clr", clr_cnt, 0);
      check("post_abort_sample", smp_cnt, 0);
    end else begin
      check("layer_timeout", (cyc >= 5000), 0);
      check("en_cycles", en_cnt, NP * NT);
      check("clr_count", clr_cnt, NP);
      check("sample_count", smp_cnt, NP);
      if (mode == 1) begin
        check("stall_low_cycles", low_cnt, 5);
`ifdef FIRE_SEQ_PERF_EN
        check("perf_stalls", stall_cycles, 5);
`endif
      end
      ram_feedback = 0;
      repeat (3) step();
      ram_feedback = 1;
      step();
      ram_feedback = 0;
      check("finish_cleared", finish, 0);
      step();
    end
  endtask

  initial begin
    rst_n = 1; start = 0; ofm_ready = 1; ram_feedback = 0;
    model_reset();
    #1;
    do_reset("reset");

    run_layer(0);
    // pixel (0,0), channel 1: window taps overlapping row -1 / column -1 are padded
    for (int t = 9; t < NT; t++) begin
      if (t <= 12 || t == 15) begin
        check("pad_flag", pix0_pad[t], 1);
        check("pad_addr", pix0_addr[t], 0);
      end
    end
    check("addr_k13", pix0_addr[13], 16);
    check("addr_k14", pix0_addr[14], 17);
    check("addr_k16", pix0_addr[16], 20);
    check("addr_k17", pix0_addr[17], 21);

    run_layer(1);
    repeat (3) run_layer(2);
    run_layer(3);
    run_layer(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
